// File: rtl/axi_sink_regfile.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | axi_sink_regfile : AXI4-Lite slave register file with WSTRB byte lanes,     |
// | fabric-fed read-only registers and SLVERR decode. Optional AXI_SINK_STATS_EN |
// | adds write/read transaction counters at indices NUM_REGS and NUM_REGS+1.     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module axi_sink_regfile #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [63:0]           RO_MASK    = 64'h0,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in
);
    localparam logic [1:0]          RESP_OKAY   = 2'b00;
    localparam logic [1:0]          RESP_SLVERR = 2'b10;
    localparam int                  STRB_W      = DATA_WIDTH / 8;
    localparam int                  ADDR_LSB    = $clog2(STRB_W);
    localparam int                  WORD_W      = ADDR_WIDTH - ADDR_LSB;
    localparam int                  IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [WORD_W:0]     NREG_X      = (WORD_W + 1)'(NUM_REGS);
    localparam logic [NUM_REGS-1:0] RO          = RO_MASK[NUM_REGS-1:0];

    typedef enum logic [0:0] {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

    w_state_t              w_state;
    r_state_t              r_state;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  aw_held;
    logic                  w_held;
    logic [WORD_W-1:0]     aw_word;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    assign S_AXI_AWREADY = ARESETN & ~aw_held & ~S_AXI_BVALID;
    assign S_AXI_WREADY  = ARESETN & ~w_held & ~S_AXI_BVALID;
    assign S_AXI_ARREADY = ARESETN & ~S_AXI_RVALID;

    // Word index is widened by one bit so the range compare works even when
    // NUM_REGS fills the whole address space.
    logic [WORD_W:0]  wr_word_x;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_is_reg;
    logic             wr_en;
    logic             commit;

    assign wr_word_x = {1'b0, aw_word};
    assign wr_idx    = aw_word[IDX_W-1:0];
    assign wr_is_reg = wr_word_x < NREG_X;
    assign wr_en     = wr_is_reg & ~RO[wr_idx];
    assign commit    = aw_held & w_held & ~S_AXI_BVALID;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state      <= W_IDLE;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_word      <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            wr_pulse     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RST_VAL;
            end
        end else begin
            wr_pulse <= '0;
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_held <= 1'b1;
                aw_word <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_held   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            case (w_state)
                W_IDLE: begin
                    if (commit) begin
                        aw_held      <= 1'b0;
                        w_held       <= 1'b0;
                        S_AXI_BVALID <= 1'b1;
                        S_AXI_BRESP  <= wr_is_reg ? RESP_OKAY : RESP_SLVERR;
                        if (wr_en) begin
                            wr_pulse[wr_idx] <= 1'b1;
                            for (int b = 0; b < STRB_W; b++) begin
                                if (w_strb_q[b]) begin
                                    regs[wr_idx][8*b +: 8] <= w_data_q[8*b +: 8];
                                end
                            end
                        end
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        w_state      <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

`ifdef AXI_SINK_STATS_EN
    localparam logic [WORD_W:0] WCNT_X = (WORD_W + 1)'(NUM_REGS);
    localparam logic [WORD_W:0] RCNT_X = (WORD_W + 1)'(NUM_REGS + 1);
    logic [31:0] wr_count;
    logic [31:0] rd_count;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (S_AXI_BVALID && S_AXI_BREADY && S_AXI_BRESP == RESP_OKAY) begin
                wr_count <= wr_count + 32'd1;
            end
            if (S_AXI_RVALID && S_AXI_RREADY && S_AXI_RRESP == RESP_OKAY) begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

    logic [WORD_W:0]       rd_word_x;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [1:0]            rd_resp;

    assign rd_word_x = {1'b0, S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB]};
    assign rd_idx    = rd_word_x[IDX_W-1:0];

    always_comb begin
        rd_val  = '0;
        rd_resp = RESP_SLVERR;
        if (rd_word_x < NREG_X) begin
            rd_resp = RESP_OKAY;
            rd_val  = RO[rd_idx] ? status_in[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH]
                                 : regs[rd_idx];
        end
`ifdef AXI_SINK_STATS_EN
        else if (rd_word_x == WCNT_X) begin
            rd_resp = RESP_OKAY;
            rd_val  = DATA_WIDTH'(wr_count);
        end else if (rd_word_x == RCNT_X) begin
            rd_resp = RESP_OKAY;
            rd_val  = DATA_WIDTH'(rd_count);
        end
`endif
    end

    // Reads sample the pre-edge register array, so a read landing on the same
    // edge as a write commit returns the old value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state      <= R_IDLE;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                        S_AXI_RDATA  <= rd_val;
                        S_AXI_RRESP  <= rd_resp;
                        S_AXI_RVALID <= 1'b1;
                        r_state      <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        r_state      <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                           S_AXI_ARADDR[ADDR_LSB-1:0], status_in};

endmodule
`default_nettype wire

// File: tb/tb_axi_sink_regfile.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for axi_sink_regfile: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them on each handshake.
module tb_axi_sink_regfile;
    localparam int          DW   = 32;
    localparam int          NR   = 16;
    localparam int          AW   = 8;
    localparam logic [31:0] RSTV = 32'h0000_00A5;
    localparam logic [1:0]  OKAY = 2'b00;
    localparam logic [1:0]  SLVE = 2'b10;
`ifdef AXI_SINK_STATS_EN
    localparam logic [7:0]  OOR  = 8'h48;
`else
    localparam logic [7:0]  OOR  = 8'h40;
`endif

    logic clk, rst_n;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [NR*DW-1:0] reg_out, status_in, snap;
    logic [NR-1:0] wr_pulse;

    typedef struct packed { logic [31:0] d; logic [1:0] r; } rexp_t;
    logic [1:0] bq[$];
    rexp_t      rq[$];
    logic [1:0] eb;
    rexp_t      er;
    int checks = 0, failures = 0;
    int pulse_cnt [NR];
    int p;

    axi_sink_regfile #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
        .RO_MASK(64'h4), .RST_VAL(RSTV)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out), .wr_pulse(wr_pulse), .status_in(status_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: one pop per B/R handshake, plus per-bit wr_pulse counting.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;
        if (bvalid && bready) begin
            if (bq.size() == 0) check("b_unexpected", {62'd0, bresp}, 64'hFFFF);
            else begin
                eb = bq.pop_front();
                check("bresp", {62'd0, bresp}, {62'd0, eb});
            end
        end
        if (rvalid && rready) begin
            if (rq.size() == 0) check("r_unexpected", {30'd0, rdata, rresp}, 64'hFFFF);
            else begin
                er = rq.pop_front();
                check("rdata_rresp", {30'd0, rdata, rresp}, {30'd0, er.d, er.r});
            end
        end
    end

    task automatic issue_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [1:0] exp);
        logic awh, wh;
        bq.push_back(exp);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
            awh = awvalid && awready;
            wh  = wvalid && wready;
            @(negedge clk);
            if (awh) awvalid = 1'b0;
            if (wh)  wvalid  = 1'b0;
        end
        if (awvalid || wvalid) begin
            check("aw_w_handshake_timeout", 64'd0, 64'd1);
            awvalid = 1'b0; wvalid = 1'b0;
        end
    endtask

    task automatic wait_hs(input bit is_b);
        int n = 0;
        while (!(is_b ? (bvalid && bready) : (rvalid && rready)) && n < 30) begin
            @(negedge clk); n++;
        end
        if (n >= 30) check(is_b ? "b_timeout" : "r_timeout", 64'd0, 64'd1);
        else @(negedge clk);
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] exp);
        issue_write(a, d, s, exp);
        wait_hs(1'b1);
    endtask

    task automatic axi_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] exp);
        logic arh;
        rq.push_back('{d: d, r: exp});
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        for (int n = 0; n < 20 && arvalid; n++) begin
            arh = arready;
            @(negedge clk);
            if (arh) arvalid = 1'b0;
        end
        if (arvalid) begin
            check("ar_handshake_timeout", 64'd0, 64'd1);
            arvalid = 1'b0;
        end
        wait_hs(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
        rst_n = 1'b0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        status_in = '0;
        status_in[2*DW +: DW] = 32'h0000_0003;   // reg 2 is RO: returns fabric status
        repeat (3) @(negedge clk);
        check("rst_awready", {63'd0, awready}, 64'd0);
        check("rst_valids", {61'd0, bvalid, rvalid, arready}, 64'd0);
        check("rst_rdata", {32'd0, rdata}, 64'd0);
        check("rst_reg_out", {63'd0, reg_out === {NR{RSTV}}}, 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_readies", {61'd0, awready, wready, arready}, 64'd7);

        // Basic write / read-back
        axi_write(8'h00, 32'd1, 4'hF, OKAY);
        axi_write(8'h04, 32'd2, 4'hF, OKAY);
        axi_write(8'h08, 32'd3, 4'hF, OKAY);
        axi_write(8'h0C, 32'd4, 4'hF, OKAY);
        axi_read(8'h00, 32'd1, OKAY);
        axi_read(8'h04, 32'd2, OKAY);
        axi_read(8'h08, 32'd3, OKAY);
        axi_read(8'h0C, 32'd4, OKAY);
        check("reg_out_ro_untouched", {32'd0, reg_out[2*DW +: DW]}, {32'd0, RSTV});

        // Byte-lane strobes and single write pulse
        axi_write(8'h04, 32'hAABB_CCDD, 4'hF, OKAY);
        #1 p = pulse_cnt[1];
        axi_write(8'h04, 32'h1122_3344, 4'b0101, OKAY);
        #1 check("wr_pulse1_once", 64'(pulse_cnt[1] - p), 64'd1);
        axi_read(8'h04, 32'hAA22_CC44, OKAY);
        axi_read(8'h07, 32'hAA22_CC44, OKAY);

        // W ahead of AW, B held off for several cycles
        @(posedge clk); #1 bready = 1'b0;
        #1 p = pulse_cnt[3];
        bq.push_back(OKAY);
        @(negedge clk);
        awaddr = 8'h0C; wdata = 32'h5555_0003; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        check("wready_low_after_w", {63'd0, wready}, 64'd0);
        wvalid = 1'b0;
        repeat (2) @(negedge clk);
        awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        for (int n = 0; n < 10 && !bvalid; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("b_held", {61'd0, bvalid, awready, wready}, 64'd4);
            @(negedge clk);
        end
        @(posedge clk); #1 bready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b_dropped", {63'd0, bvalid}, 64'd0);
        #1 check("wr_pulse3_once", 64'(pulse_cnt[3] - p), 64'd1);
        axi_read(8'h0C, 32'h5555_0003, OKAY);

        // Read-only register
        status_in[2*DW +: DW] = 32'hDEAD_BEEF;
        axi_write(8'h08, 32'h0, 4'hF, OKAY);
        #1 check("ro_no_pulse", 64'(pulse_cnt[2]), 64'd0);
        axi_read(8'h08, 32'hDEAD_BEEF, OKAY);

        // Out of range and top-of-range boundary
        snap = reg_out;
        axi_write(OOR, 32'hFFFF_FFFF, 4'hF, SLVE);
        axi_read(OOR, 32'h0, SLVE);
        axi_read(8'hFC, 32'h0, SLVE);
        check("oor_reg_out_same", {63'd0, reg_out === snap}, 64'd1);
        axi_read(8'h3C, RSTV, OKAY);

        // Reset while B pending
        @(posedge clk); #1 bready = 1'b0;
        issue_write(8'h10, 32'h1234_5678, 4'hF, OKAY);
        for (int n = 0; n < 10 && !bvalid; n++) @(negedge clk);
        check("b_pending_before_rst", {63'd0, bvalid}, 64'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_bvalid", {62'd0, bvalid, awready}, 64'd0);
        check("rst_async_regs", {63'd0, reg_out === {NR{RSTV}}}, 64'd1);
        bq.delete();
        @(posedge clk); #1 bready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        axi_read(8'h10, RSTV, OKAY);
        axi_read(8'h00, RSTV, OKAY);

        repeat (3) @(negedge clk);
        check("queues_drained", 64'(bq.size() + rq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
